vga_draw_arbiter: RTL and testbench

Shares the single VGA pixel-write port and the map-background RAM address between the four drawing engines (tower, car, middle-states, laser) in the game datapath. Replaces the fixed combinational priority mux with a request/grant scheme: one engine owns the port for a whole sprite or screen burst, so pixels from different engines never interleave. Sits between the drawing engines and the VGA adapter and background RAM, inside the game data-flow block.

---
 rtl/vga_draw_arbiter.sv | 161 ++++++++++++++++
 tb/tb_vga_draw_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vga_draw_arbiter.sv
// Request/grant arbiter sharing the VGA pixel-write port and background RAM address among the drawing engines.
// Define VGA_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (index 0 highest).
module vga_draw_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int MAX_HOLD = 19200
) (
   input  logic                    Clock,
   input  logic                    resetn,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ-1:0]      done,
   input  logic [NUM_REQ-1:0]      wr_en_in,
   input  logic [9*NUM_REQ-1:0]    colour_in,
   input  logic [15*NUM_REQ-1:0]   coord_in,
   input  logic [15*NUM_REQ-1:0]   mem_add_in,
   output logic [NUM_REQ-1:0]      grant,
   output logic                    busy,
   output logic                    timeout,
   output logic [8:0]              colour,
   output logic [14:0]             coordinates,
   output logic                    VGA_write_enable,
   output logic [14:0]             mem_add
);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t               state, state_next;
   logic [NUM_REQ-1:0]   grant_next, mask, mask_next, eligible, winner;
   logic [14:0]          hold_cnt, hold_next;
   logic                 timeout_next, we_next;
   logic [8:0]           colour_next, owner_colour;
   logic [14:0]          coord_next, owner_coord;

   assign eligible = req & ~mask;
   assign busy     = (state == GRANT) || (state == RELEASE);

   // grant is one-hot or zero, so OR-ing the selected slices gives the owner's data (zero when idle)
   always_comb begin
      owner_colour = '0;
      owner_coord  = '0;
      mem_add      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            owner_colour = owner_colour | colour_in[9*i +: 9];
            owner_coord  = owner_coord  | coord_in[15*i +: 15];
            mem_add      = mem_add      | mem_add_in[15*i +: 15];
         end
      end
   end

`ifdef VGA_ARB_ROUND_ROBIN_EN
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IW-1:0] rr_ptr, rr_ptr_next, win_idx, cand;
   logic          found;

   // Search starts just after the last owner and wraps
   always_comb begin
      winner  = '0;
      win_idx = '0;
      cand    = '0;
      found   = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand = IW'((int'(rr_ptr) + 1 + off) % NUM_REQ);
         if (!found && eligible[cand]) begin
            found       = 1'b1;
            win_idx     = cand;
            winner[cand] = 1'b1;
         end
      end
   end
`else
   assign winner = eligible & (~eligible + NUM_REQ'(1));
`endif

   always_comb begin
      state_next   = state;
      grant_next   = grant;
      hold_next    = hold_cnt;
      mask_next    = mask & req;
      timeout_next = 1'b0;
      we_next      = 1'b0;
      colour_next  = colour;
      coord_next   = coordinates;
`ifdef VGA_ARB_ROUND_ROBIN_EN
      rr_ptr_next  = rr_ptr;
`endif
      case (state)
         IDLE: begin
            grant_next  = '0;
            colour_next = '0;
            coord_next  = '0;
            if (|eligible) begin
               state_next = GRANT;
               grant_next = winner;
               hold_next  = '0;
`ifdef VGA_ARB_ROUND_ROBIN_EN
               rr_ptr_next = win_idx;
`endif
            end
         end
         GRANT: begin
            if (|(wr_en_in & grant)) begin
               we_next     = 1'b1;
               colour_next = owner_colour;
               coord_next  = owner_coord;
            end
            // A normal end of burst takes precedence over the hold limit
            if (|(grant & (done | ~req))) begin
               state_next = RELEASE;
               grant_next = '0;
            end else if (hold_cnt == 15'(MAX_HOLD - 1)) begin
               state_next   = RELEASE;
               grant_next   = '0;
               timeout_next = 1'b1;
               mask_next    = mask_next | grant;
            end else begin
               hold_next = hold_cnt + 15'd1;
            end
         end
         RELEASE: begin
            grant_next  = '0;
            colour_next = '0;
            coord_next  = '0;
            state_next  = IDLE;
         end
         default: begin
            state_next = IDLE;
            grant_next = '0;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!resetn) begin
         state            <= IDLE;
         grant            <= '0;
         hold_cnt         <= '0;
         mask             <= '0;
         timeout          <= 1'b0;
         VGA_write_enable <= 1'b0;
         colour           <= '0;
         coordinates      <= '0;
`ifdef VGA_ARB_ROUND_ROBIN_EN
         rr_ptr           <= IW'(NUM_REQ - 1);
`endif
      end else begin
         state            <= state_next;
         grant            <= grant_next;
         hold_cnt         <= hold_next;
         mask             <= mask_next;
         timeout          <= timeout_next;
         VGA_write_enable <= we_next;
         colour           <= colour_next;
         coordinates      <= coord_next;
`ifdef VGA_ARB_ROUND_ROBIN_EN
         rr_ptr           <= rr_ptr_next;
`endif
      end
   end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: vector table plus contention, timeout and reset sequences.
module tb_vga_draw_arbiter;

   logic        Clock = 1'b0;
   logic        resetn;
   logic [3:0]  req, done, wr_en_in;
   logic [35:0] colour_in;
   logic [59:0] coord_in, mem_add_in;
   logic [3:0]  grant;
   logic        busy, timeout, VGA_write_enable;
   logic [8:0]  colour;
   logic [14:0] coordinates, mem_add;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic        rstn;
      logic [3:0]  req, done, wr;
      int          eng;
      logic [8:0]  col;
      logic [14:0] crd;
      logic [3:0]  eg;
      logic        eb, et, ew, chk;
      logic [8:0]  ec;
      logic [14:0] ecr;
   } vec_t;

   vec_t vecs[$];

   vga_draw_arbiter #(.NUM_REQ(4), .MAX_HOLD(16)) dut (
      .Clock(Clock), .resetn(resetn), .req(req), .done(done), .wr_en_in(wr_en_in),
      .colour_in(colour_in), .coord_in(coord_in), .mem_add_in(mem_add_in),
      .grant(grant), .busy(busy), .timeout(timeout), .colour(colour),
      .coordinates(coordinates), .VGA_write_enable(VGA_write_enable), .mem_add(mem_add)
   );

   always #5 Clock = ~Clock;

   function automatic logic [14:0] memFor(input logic [3:0] g);
      case (g)
         4'b0001: return 15'h0111;
         4'b0010: return 15'h0222;
         4'b0100: return 15'h0333;
         4'b1000: return 15'h0444;
         default: return 15'h0000;
      endcase
   endfunction

   task automatic applyStimulus(input logic rstn, input logic [3:0] r, input logic [3:0] d,
                                input logic [3:0] w, input int eng, input logic [8:0] col,
                                input logic [14:0] crd);
      resetn   = rstn;
      req      = r;
      done     = d;
      wr_en_in = w;
      for (int i = 0; i < 4; i++) begin
         colour_in[9*i +: 9]  = (i == eng) ? col : 9'(16 + i);
         coord_in[15*i +: 15] = (i == eng) ? crd : 15'(1000 + i);
      end
      @(posedge Clock);
      #1;
   endtask

   task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic [3:0] eg, input logic eb, input logic et,
                              input logic ew, input logic chk, input logic [8:0] ec,
                              input logic [14:0] ecr);
      compareVal({name, " grant"}, 32'(grant), 32'(eg));
      compareVal({name, " busy"}, 32'(busy), 32'(eb));
      compareVal({name, " timeout"}, 32'(timeout), 32'(et));
      compareVal({name, " we"}, 32'(VGA_write_enable), 32'(ew));
      compareVal({name, " mem_add"}, 32'(mem_add), 32'(memFor(eg)));
      if (chk) begin
         compareVal({name, " colour"}, 32'(colour), 32'(ec));
         compareVal({name, " coord"}, 32'(coordinates), 32'(ecr));
      end
   endtask

   task automatic addVec(input logic rstn, input logic [3:0] r, input logic [3:0] d, input logic [3:0] w,
                         input int eng, input logic [8:0] col, input logic [14:0] crd,
                         input logic [3:0] eg, input logic eb, input logic et, input logic ew,
                         input logic chk, input logic [8:0] ec, input logic [14:0] ecr);
      vec_t v;
      v.rstn = rstn; v.req = r; v.done = d; v.wr = w; v.eng = eng; v.col = col; v.crd = crd;
      v.eg = eg; v.eb = eb; v.et = et; v.ew = ew; v.chk = chk; v.ec = ec; v.ecr = ecr;
      vecs.push_back(v);
   endtask

   initial begin
      int          owners[5];
      logic [3:0]  reqv[5];
      logic [3:0]  oh;

      mem_add_in = {15'h0444, 15'h0333, 15'h0222, 15'h0111};
      resetn = 1'b0; req = '0; done = '0; wr_en_in = '0; colour_in = '0; coord_in = '0;

      // Single request, blocked writes, last pixel and the dead cycle between owners
      addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 9'h000, 15'd0,     4'b0000, 0, 0, 0, 1, 9'h000, 15'd0);
      addVec(1, 4'b0000, 4'b0000, 4'b0000, 0, 9'h000, 15'd0,     4'b0000, 0, 0, 0, 1, 9'h000, 15'd0);
      addVec(1, 4'b0100, 4'b0000, 4'b0000, 0, 9'h000, 15'd0,     4'b0100, 1, 0, 0, 1, 9'h000, 15'd0);
      addVec(1, 4'b0100, 4'b0000, 4'b0000, 0, 9'h000, 15'd0,     4'b0100, 1, 0, 0, 1, 9'h000, 15'd0);
      addVec(1, 4'b0100, 4'b0000, 4'b0100, 2, 9'h1A3, 15'd321,   4'b0100, 1, 0, 1, 1, 9'h1A3, 15'd321);
      addVec(1, 4'b0100, 4'b0000, 4'b0000, 0, 9'h000, 15'd0,     4'b0100, 1, 0, 0, 0, 9'h000, 15'd0);
      addVec(1, 4'b0100, 4'b0100, 4'b0000, 0, 9'h000, 15'd0,     4'b0000, 1, 0, 0, 0, 9'h000, 15'd0);
      addVec(1, 4'b0000, 4'b0000, 4'b0000, 0, 9'h000, 15'd0,     4'b0000, 0, 0, 0, 1, 9'h000, 15'd0);
      addVec(1, 4'b0010, 4'b0000, 4'b0000, 0, 9'h000, 15'd0,     4'b0010, 1, 0, 0, 1, 9'h000, 15'd0);
      addVec(1, 4'b0010, 4'b0000, 4'b1000, 3, 9'h1FF, 15'd7,     4'b0010, 1, 0, 0, 1, 9'h000, 15'd0);
      addVec(1, 4'b0010, 4'b0000, 4'b0010, 1, 9'h0AB, 15'd12345, 4'b0010, 1, 0, 1, 1, 9'h0AB, 15'd12345);
      addVec(1, 4'b0000, 4'b0000, 4'b0000, 0, 9'h000, 15'd0,     4'b0000, 1, 0, 0, 0, 9'h000, 15'd0);
      addVec(1, 4'b0000, 4'b0000, 4'b0000, 0, 9'h000, 15'd0,     4'b0000, 0, 0, 0, 1, 9'h000, 15'd0);
      addVec(1, 4'b1000, 4'b0000, 4'b0000, 0, 9'h000, 15'd0,     4'b1000, 1, 0, 0, 1, 9'h000, 15'd0);
      addVec(1, 4'b1000, 4'b1000, 4'b1000, 3, 9'h155, 15'd999,   4'b0000, 1, 0, 1, 1, 9'h155, 15'd999);
      addVec(1, 4'b0100, 4'b0000, 4'b0000, 0, 9'h000, 15'd0,     4'b0000, 0, 0, 0, 1, 9'h000, 15'd0);
      addVec(1, 4'b0100, 4'b0000, 4'b0000, 0, 9'h000, 15'd0,     4'b0100, 1, 0, 0, 1, 9'h000, 15'd0);
      addVec(1, 4'b0000, 4'b0000, 4'b0000, 0, 9'h000, 15'd0,     4'b0000, 1, 0, 0, 1, 9'h000, 15'd0);
      addVec(1, 4'b0000, 4'b0000, 4'b0000, 0, 9'h000, 15'd0,     4'b0000, 0, 0, 0, 1, 9'h000, 15'd0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rstn, vecs[i].req, vecs[i].done, vecs[i].wr,
                       vecs[i].eng, vecs[i].col, vecs[i].crd);
         checkOutput($sformatf("vec%0d", i), vecs[i].eg, vecs[i].eb, vecs[i].et,
                     vecs[i].ew, vecs[i].chk, vecs[i].ec, vecs[i].ecr);
      end

      // Contention: each owner holds two cycles, pulses done, then one dead cycle
`ifdef VGA_ARB_ROUND_ROBIN_EN
      owners[0] = 0; owners[1] = 1; owners[2] = 2; owners[3] = 3; owners[4] = 0;
      reqv[0] = 4'b1111; reqv[1] = 4'b1111; reqv[2] = 4'b1111; reqv[3] = 4'b1111; reqv[4] = 4'b1111;
`else
      owners[0] = 0; owners[1] = 0; owners[2] = 1; owners[3] = 2; owners[4] = 3;
      reqv[0] = 4'b1111; reqv[1] = 4'b1111; reqv[2] = 4'b1110; reqv[3] = 4'b1100; reqv[4] = 4'b1000;
`endif
      applyStimulus(0, 4'b0000, 4'b0000, 4'b0000, 0, 9'h000, 15'd0);
      checkOutput("cont reset", 4'b0000, 0, 0, 0, 1, 9'h000, 15'd0);
      for (int k = 0; k < 5; k++) begin
         oh = 4'(1) << owners[k];
         applyStimulus(1, reqv[k], 4'b0000, 4'b0000, 0, 9'h000, 15'd0);
         checkOutput($sformatf("cont%0d grant", k), oh, 1, 0, 0, 1, 9'h000, 15'd0);
         applyStimulus(1, reqv[k], 4'b0000, 4'b0000, 0, 9'h000, 15'd0);
         checkOutput($sformatf("cont%0d hold", k), oh, 1, 0, 0, 1, 9'h000, 15'd0);
         applyStimulus(1, reqv[k], oh, 4'b0000, 0, 9'h000, 15'd0);
         checkOutput($sformatf("cont%0d release", k), 4'b0000, 1, 0, 0, 1, 9'h000, 15'd0);
         applyStimulus(1, reqv[k], 4'b0000, 4'b0000, 0, 9'h000, 15'd0);
         checkOutput($sformatf("cont%0d dead", k), 4'b0000, 0, 0, 0, 1, 9'h000, 15'd0);
      end

      // Timeout with hold limit 16, then masking of the timed-out engine
      applyStimulus(0, 4'b0000, 4'b0000, 4'b0000, 0, 9'h000, 15'd0);
      checkOutput("to reset", 4'b0000, 0, 0, 0, 1, 9'h000, 15'd0);
      applyStimulus(1, 4'b0001, 4'b0000, 4'b0000, 0, 9'h000, 15'd0);
      checkOutput("to grant", 4'b0001, 1, 0, 0, 1, 9'h000, 15'd0);
      for (int j = 1; j <= 15; j++) begin
         applyStimulus(1, 4'b0001, 4'b0000, 4'b0000, 0, 9'h000, 15'd0);
         checkOutput($sformatf("to hold%0d", j), 4'b0001, 1, 0, 0, 1, 9'h000, 15'd0);
      end
      applyStimulus(1, 4'b0001, 4'b0000, 4'b0000, 0, 9'h000, 15'd0);
      checkOutput("to pulse", 4'b0000, 1, 1, 0, 1, 9'h000, 15'd0);
      applyStimulus(1, 4'b0011, 4'b0000, 4'b0000, 0, 9'h000, 15'd0);
      checkOutput("to after", 4'b0000, 0, 0, 0, 1, 9'h000, 15'd0);
      applyStimulus(1, 4'b0011, 4'b0000, 4'b0000, 0, 9'h000, 15'd0);
      checkOutput("to masked grant1", 4'b0010, 1, 0, 0, 1, 9'h000, 15'd0);
      applyStimulus(1, 4'b0011, 4'b0010, 4'b0000, 0, 9'h000, 15'd0);
      checkOutput("to done1", 4'b0000, 1, 0, 0, 1, 9'h000, 15'd0);
      applyStimulus(1, 4'b0011, 4'b0000, 4'b0000, 0, 9'h000, 15'd0);
      checkOutput("to dead1", 4'b0000, 0, 0, 0, 1, 9'h000, 15'd0);
      applyStimulus(1, 4'b0011, 4'b0000, 4'b0000, 0, 9'h000, 15'd0);
      checkOutput("to still masked", 4'b0010, 1, 0, 0, 1, 9'h000, 15'd0);
      applyStimulus(1, 4'b0010, 4'b0000, 4'b0000, 0, 9'h000, 15'd0);
      checkOutput("to req0 low", 4'b0010, 1, 0, 0, 1, 9'h000, 15'd0);
      applyStimulus(1, 4'b0011, 4'b0010, 4'b0000, 0, 9'h000, 15'd0);
      checkOutput("to done1b", 4'b0000, 1, 0, 0, 1, 9'h000, 15'd0);
      applyStimulus(1, 4'b0011, 4'b0000, 4'b0000, 0, 9'h000, 15'd0);
      checkOutput("to dead2", 4'b0000, 0, 0, 0, 1, 9'h000, 15'd0);
      applyStimulus(1, 4'b0011, 4'b0000, 4'b0000, 0, 9'h000, 15'd0);
      checkOutput("to unmasked grant0", 4'b0001, 1, 0, 0, 1, 9'h000, 15'd0);

      // Reset in the middle of a burst with a write in flight
      applyStimulus(1, 4'b0001, 4'b0000, 4'b0001, 0, 9'h1C7, 15'd4321);
      checkOutput("rst write", 4'b0001, 1, 0, 1, 1, 9'h1C7, 15'd4321);
      applyStimulus(0, 4'b0001, 4'b0000, 4'b0001, 0, 9'h0EE, 15'd55);
      checkOutput("rst mid", 4'b0000, 0, 0, 0, 1, 9'h000, 15'd0);
      applyStimulus(1, 4'b1111, 4'b0000, 4'b0000, 0, 9'h000, 15'd0);
      checkOutput("rst pointer", 4'b0001, 1, 0, 0, 1, 9'h000, 15'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
